button_event_fsm: RTL
=====================

# button_event_fsm

Downstream consumer of the debounce FSM's `debounce` level. It converts the clean button level into one-cycle event pulses: press, release, single click, double click and long press. It also keeps a wrapping press counter. Application logic (LED control, menu stepping) consumes these pulses directly, so it never sees a level.

## Interface
- `LONG_CYCLES`, default 50_000_000 — hold duration, in clk cycles, that qualifies a long press; legal range ≥ 2.
- `DCLICK_CYCLES`, default 12_500_000 — window, in clk cycles after a short release, in which a second press counts as a double click; legal range ≥ 2.
- `CNT_W`, default 8 — width of `press_count`.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset  in  1` — asynchronous, active-high; clears all state.
- `debounce  in  1` — clean button level from the debounce stage, synchronous to `clk`.
- `clear_count  in  1` — synchronous clear of `press_count`.
- `press  out  1` — one-cycle pulse on each debounced rising edge.
- `release  out  1` — one-cycle pulse on each debounced falling edge.
- `single_click  out  1` — one-cycle pulse when a short press is not followed by a second press within the window.
- `double_click  out  1` — one-cycle pulse, coincident with `press`, for a second press inside the window.
- `long_press  out  1` — one-cycle pulse when a press has been held `LONG_CYCLES` cycles.
- `press_count  out  CNT_W` — number of presses since reset or clear; wraps.

## Operation
- Edge detection: `d1 <= debounce`, `d2 <= d1`.
  - rise = `d1 & ~d2`; fall = `~d1 & d2`.
  - `press` and `release` are registered from rise and fall.
- State machine, states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED:
  - IDLE: rise → PRESSED, timer cleared to 0.
  - PRESSED: timer increments each cycle.
    - fall → WAIT_SECOND, timer cleared.
    - timer == `LONG_CYCLES`-1 with no fall → LONG_HELD; pulse `long_press`.
  - LONG_HELD: fall → IDLE. No click event is produced.
  - WAIT_SECOND: timer increments each cycle.
    - rise → SECOND_PRESSED; pulse `double_click`.
    - timer == `DCLICK_CYCLES`-1 with no rise → IDLE; pulse `single_click`.
  - SECOND_PRESSED: fall → IDLE. No long-press detection in this state.
- Timer: one shared counter of width `$clog2(max(LONG_CYCLES, DCLICK_CYCLES))`. It holds 0 in IDLE, LONG_HELD and SECOND_PRESSED.
- `press_count`: increments on every rise, including second presses, and wraps from 2^CNT_W-1 to 0.
  - `clear_count` with no rise → 0.
  - `clear_count` on the same cycle as a rise → 1 (clear first, then count).
- Simultaneous events:
  - fall on PRESSED's terminal cycle counts as a short press; no `long_press`.
  - rise on WAIT_SECOND's terminal cycle counts as a double click; no `single_click`.
- Reset: all outputs, `d1`, `d2`, timer, `press_count` → 0; state → IDLE.
  - Mid-operation reset abandons the event in progress with no pulse.
  - If `debounce` is high when reset deasserts, a `press` is generated, because `d2` restarts at 0.

## Timing
- `debounce` first sampled high at edge N → `press` high for the cycle after edge N+1. Latency is 2 edges; `release` is symmetric.
- `long_press` asserts exactly `LONG_CYCLES` cycles after `press` asserted.
- `single_click` asserts exactly `DCLICK_CYCLES` cycles after `release` asserted.
- `double_click` asserts in the same cycle as the second `press`.
- `press_count` updates in the same cycle `press` asserts.
- Every event output is high for exactly one cycle. At most one of `single_click`, `double_click`, `long_press` is high in any cycle.

## Structure
- Package `button_pkg` holds:
  - the state enum `btn_state_t` (IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED);
  - a helper function returning the timer width from the two parameters.
- Sub-module `edge_pulse` contains the `d1`/`d2` pipeline and the registered rise/fall pulses. It is reused for other button inputs.

## Test plan
All scenarios use `LONG_CYCLES`=8, `DCLICK_CYCLES`=6, `CNT_W`=3.
- Short press: `debounce` high for 3 cycles then low, idle 10 cycles.
  - Expect `press`, `release`, then `single_click` exactly 6 cycles after `release`.
  - `press_count`=1; no `long_press` or `double_click`.
- Double click: press 3 cycles, release, re-press 2 cycles later.
  - Expect `double_click` coincident with the second `press`, `press_count`=2, no `single_click`.
- Long press: hold high for 20 cycles.
  - Expect `long_press` exactly 8 cycles after `press`.
  - Releasing afterwards gives `release` only, no click pulse.
- Boundaries:
  - Release landing on PRESSED's terminal cycle → short press, no `long_press`.
  - Second rise landing on WAIT_SECOND's terminal cycle → `double_click`, no `single_click`.
- Counter: 9 separate presses → `press_count` wraps 7→0→1.
  - `clear_count` on the same cycle as a press → `press_count`=1.
- Reset:
  - Assert `reset` mid-hold (PRESSED, timer=4) → all outputs 0, state IDLE, no pulse.
  - Deassert with `debounce` still high → `press` 2 edges later.

Source files
------------

// File: rtl/button_event_fsm_pkg.sv
// button_pkg: shared types and helpers for the button event logic.
//   btn_state_t  - click/long-press state machine encoding
//   timer_width  - width of the shared event timer for a given pair of
//                  long-press and double-click windows
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } btn_state_t;

    // The timer only ever counts up to (window - 1), so clog2 of the larger
    // window is enough. Clamp to 1 bit so a degenerate window still builds.
    function automatic int timer_width(int long_cycles, int dclick_cycles);
        int m;
        m = (long_cycles > dclick_cycles) ? long_cycles : dclick_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_event_fsm_if.sv
// button_event_if: button level in, event pulses and press counter out.
//   debounce      - clean button level (driven by master)
//   clear_count   - synchronous clear of press_count (driven by master)
//   press         - pulse on debounced rising edge
//   release_evt   - pulse on debounced falling edge
//   single_click  - pulse when a short press gets no second press in time
//   double_click  - pulse, with press, on a second press inside the window
//   long_press    - pulse when a press has been held long enough
//   press_count   - wrapping count of presses
// "release" is a reserved word, hence release_evt.
interface button_event_if #(
    parameter int CNT_W = 8
);
    logic             debounce;
    logic             clear_count;
    logic             press;
    logic             release_evt;
    logic             single_click;
    logic             double_click;
    logic             long_press;
    logic [CNT_W-1:0] press_count;

    modport master (
        output debounce, clear_count,
        input  press, release_evt, single_click, double_click, long_press,
               press_count
    );

    modport slave (
        input  debounce, clear_count,
        output press, release_evt, single_click, double_click, long_press,
               press_count
    );
endinterface

// File: rtl/button_event_fsm_edge_pulse.sv
// edge_pulse: two-stage level history with rise/fall detection.
//   clk, reset  - clock, async active-high reset
//   din         - level input, synchronous to clk
//   rise, fall  - combinational edge flags from the d1/d2 history
//   rise_pulse  - rise registered (one-cycle pulse)
//   fall_pulse  - fall registered (one-cycle pulse)
// d2 restarts at 0, so a level that is already high when reset drops is
// seen as a rising edge.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic rise_pulse,
    output logic fall_pulse
);
    logic d1, d2;

    assign rise = d1 & ~d2;
    assign fall = ~d1 & d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1         <= 1'b0;
            d2         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            d1         <= din;
            d2         <= d1;
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end
endmodule

// File: rtl/button_event_fsm.sv
// button_event_fsm: turns a debounced button level into one-cycle events
// (press, release, single click, double click, long press) and keeps a
// wrapping press counter.
//   clk    - clock
//   reset  - async active-high reset, clears all state
//   bus    - button_event_if slave (level/clear in, pulses/count out)
// The FSM acts on the combinational rise/fall from edge_pulse, so its
// registered outputs line up with the registered press/release pulses.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 12_500_000,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           reset,
    button_event_if.slave  bus
);
    localparam int TW = timer_width(LONG_CYCLES, DCLICK_CYCLES);
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);

    logic             rise, fall, press_q, release_q;
    btn_state_t       state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             sc_nxt, dc_nxt, lp_nxt;
    logic             sc_q, dc_q, lp_q;
    logic [CNT_W-1:0] count;

    edge_pulse u_edge (
        .clk        (clk),
        .reset      (reset),
        .din        (bus.debounce),
        .rise       (rise),
        .fall       (fall),
        .rise_pulse (press_q),
        .fall_pulse (release_q)
    );

    // Timer defaults to 0 and only counts in PRESSED / WAIT_SECOND. The
    // edge checks come before the terminal-count checks so an edge landing
    // on the last cycle of a window wins.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        sc_nxt    = 1'b0;
        dc_nxt    = 1'b0;
        lp_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt = WAIT_SECOND;
                end else if (timer == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    lp_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            LONG_HELD: begin
                if (fall) state_nxt = IDLE;
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_nxt = SECOND_PRESSED;
                    dc_nxt    = 1'b1;
                end else if (timer == DCLICK_LAST) begin
                    state_nxt = IDLE;
                    sc_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            SECOND_PRESSED: begin
                if (fall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            sc_q  <= 1'b0;
            dc_q  <= 1'b0;
            lp_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            sc_q  <= sc_nxt;
            dc_q  <= dc_nxt;
            lp_q  <= lp_nxt;
        end
    end

    // Clear takes effect before the increment when both land together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                count <= '0;
        else if (rise)            count <= (bus.clear_count ? '0 : count) + CNT_W'(1);
        else if (bus.clear_count) count <= '0;
    end

    assign bus.press        = press_q;
    assign bus.release_evt  = release_q;
    assign bus.single_click = sc_q;
    assign bus.double_click = dc_q;
    assign bus.long_press   = lp_q;
    assign bus.press_count  = count;
endmodule
